// File: rtl/mc_ext_bus_arbiter.sv
// mc_ext_bus_arbiter
// Round-robin arbiter for the external masters of the memory controller's
// shared bus. It owns the bus-request/bus-grant handshake with the controller
// (mc_br_o -> mc_br_i, mc_bg_o -> mc_bg_i) and hands the granted bus to one
// master at a time.
//
// Optional feature macro: MC_ARB_TIMEOUT_EN
//   defined   - a hold counter forces a release after MAX_HOLD ownership
//               cycles when another master is waiting (timeout_o pulses).
//   undefined - no hold counter, ownership is unlimited, timeout_o is 0.
//
// Every output comes straight from a flop (busy_o decodes the state
// register), so there is no combinational path from any input to any output.
module mc_ext_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 255
) (
  input  logic                           mc_clk,
  input  logic                           mc_rst_n,
  input  logic [NUM_MASTERS-1:0]         ext_req_i,
  output logic [NUM_MASTERS-1:0]         ext_gnt_o,
  output logic                           mc_br_o,
  input  logic                           mc_bg_i,
  output logic [$clog2(NUM_MASTERS)-1:0] owner_o,
  output logic                           busy_o,
  output logic                           timeout_o
);

  localparam int OW = $clog2(NUM_MASTERS);
  localparam logic [OW-1:0] LAST_IDX = OW'(NUM_MASTERS - 1);

  // Reject parameter sets the arbiter was not built for.
  generate
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || MAX_HOLD < 1) begin : g_param_check
      $error("mc_ext_bus_arbiter: NUM_MASTERS must be 2..8 and MAX_HOLD >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_OWN  = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [OW-1:0]          owner_reg, owner_next;
  logic [OW-1:0]          rr_ptr_reg, rr_ptr_next;
  logic [NUM_MASTERS-1:0] gnt_reg, gnt_next;
  logic                   br_reg, br_next;

  logic [NUM_MASTERS-1:0] owner_onehot;
  logic [NUM_MASTERS-1:0] other_req;
  logic                   owner_req;
  logic [OW-1:0]          rr_pick;
  logic                   force_rel;

  // One-hot decode of the latched owner index, used both for the grant
  // vector and to separate the owner's request from everybody else's.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_owner_dec
      assign owner_onehot[gi] = (owner_reg == OW'(gi));
    end
  endgenerate

  assign owner_req = |(ext_req_i & owner_onehot);
  assign other_req = ext_req_i & ~owner_onehot;

  // Cyclic search for the first requester at or after the round-robin pointer.
  always_comb begin : p_rr_pick
    logic          found;
    logic [OW:0]   cand;
    found   = 1'b0;
    cand    = '0;
    rr_pick = rr_ptr_reg;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = {1'b0, rr_ptr_reg} + (OW+1)'(i);
      if (cand >= (OW+1)'(NUM_MASTERS)) begin
        cand = cand - (OW+1)'(NUM_MASTERS);
      end
      if (!found && ext_req_i[cand[OW-1:0]]) begin
        rr_pick = cand[OW-1:0];
        found   = 1'b1;
      end
    end
  end

`ifdef MC_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  logic [HW-1:0] hold_reg, hold_next, hold_inc;
  logic          timeout_reg, timeout_next;

  // The counter value including the current OWN cycle; a release decided on
  // it ends ownership after exactly MAX_HOLD granted cycles.
  assign hold_inc  = (hold_reg == HOLD_MAX) ? hold_reg : hold_reg + HW'(1);
  assign force_rel = (hold_inc == HOLD_MAX) && (|other_req);

  // Hold counter runs only while owning; it restarts from zero on each grant.
  always_comb begin
    hold_next    = '0;
    timeout_next = 1'b0;
    if (state_reg == ST_OWN) begin
      hold_next    = hold_inc;
      timeout_next = owner_req && force_rel;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge mc_clk or negedge mc_rst_n) begin
    if (!mc_rst_n) begin
      hold_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      hold_reg    <= hold_next;
      timeout_reg <= timeout_next;
    end
  end

  assign timeout_o = timeout_reg;
`else
  assign force_rel = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Next-state and registered-output logic of the arbitration FSM.
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    gnt_next    = '0;
    br_next     = br_reg;
    case (state_reg)
      ST_IDLE: begin
        br_next = 1'b0;
        if (|ext_req_i) begin
          owner_next = rr_pick;
          br_next    = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!owner_req) begin
          // Abort before grant: pointer untouched, the master keeps priority.
          br_next    = 1'b0;
          state_next = ST_REL;
        end else if (mc_bg_i) begin
          gnt_next   = owner_onehot;
          state_next = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!owner_req || force_rel) begin
          // Voluntary or forced release wins over a simultaneous revoke.
          br_next     = 1'b0;
          rr_ptr_next = (owner_reg == LAST_IDX) ? '0 : owner_reg + OW'(1);
          state_next  = ST_REL;
        end else if (!mc_bg_i) begin
          // Controller revoked the bus: keep requesting for the same owner.
          state_next = ST_REQ;
        end else begin
          gnt_next = owner_onehot;
        end
      end
      ST_REL: begin
        br_next = 1'b0;
        if (!mc_bg_i) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        br_next    = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge mc_clk or negedge mc_rst_n) begin
    if (!mc_rst_n) begin
      state_reg  <= ST_IDLE;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
      gnt_reg    <= '0;
      br_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      rr_ptr_reg <= rr_ptr_next;
      gnt_reg    <= gnt_next;
      br_reg     <= br_next;
    end
  end

  assign ext_gnt_o = gnt_reg;
  assign mc_br_o   = br_reg;
  assign owner_o   = owner_reg;
  assign busy_o    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mc_ext_bus_arbiter.sv
// Testbench for mc_ext_bus_arbiter (4 masters, MAX_HOLD = 8).
// Directed vector table, hand-written multi-cycle sequences, then random
// stimulus compared against a tenure-level reference model.
// Build with MC_ARB_TIMEOUT_EN defined to also cover the forced release.
module tb_mc_ext_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;
`ifdef MC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         mc_clk = 1'b0;
  logic         mc_rst_n;
  logic [N-1:0] ext_req_i;
  logic [N-1:0] ext_gnt_o;
  logic         mc_br_o;
  logic         mc_bg_i;
  logic [1:0]   owner_o;
  logic         busy_o;
  logic         timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  mc_ext_bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MH)) dut (
    .mc_clk    (mc_clk),
    .mc_rst_n  (mc_rst_n),
    .ext_req_i (ext_req_i),
    .ext_gnt_o (ext_gnt_o),
    .mc_br_o   (mc_br_o),
    .mc_bg_i   (mc_bg_i),
    .owner_o   (owner_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  always #5 mc_clk = ~mc_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] req;
    logic       bg;
    logic [3:0] gnt;
    logic       br;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t tbl [25];

  // Reference model state: one tenure at a time.
  bit m_active, m_granted, m_leaving, m_br, m_to;
  int m_owner, m_ptr, m_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mc_clk);
    @(negedge mc_clk);
  endtask

  function automatic logic [8:0] outs();
    return {ext_gnt_o, mc_br_o, owner_o, busy_o, timeout_o};
  endfunction

  function automatic vec_t mk(input logic [3:0] r, input logic b, input logic [3:0] g,
                              input logic br, input logic [1:0] o, input logic bz);
    vec_t v;
    v.req = r; v.bg = b; v.gnt = g; v.br = br; v.owner = o; v.busy = bz;
    return v;
  endfunction

  task automatic model_reset();
    m_active = 0; m_granted = 0; m_leaving = 0; m_br = 0; m_to = 0;
    m_owner = 0; m_ptr = 0; m_hold = 0;
  endtask

  task automatic do_reset();
    mc_rst_n  = 1'b0;
    ext_req_i = '0;
    mc_bg_i   = 1'b0;
    tick();
    tick();
    mc_rst_n = 1'b1;
    model_reset();
  endtask

  function automatic int rr_first(input logic [3:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // One clock edge of the arbitration rules, applied to the sampled inputs.
  task automatic model_step(input logic [3:0] r, input logic b);
    logic [3:0] others;
    m_to = 0;
    if (!m_active) begin
      if (r != 0) begin
        m_owner = rr_first(r, m_ptr);
        m_active = 1; m_br = 1; m_granted = 0; m_leaving = 0;
      end
    end else if (m_leaving) begin
      if (!b) m_active = 0;
    end else if (!m_granted) begin
      if (!r[m_owner]) begin
        m_br = 0; m_leaving = 1;
      end else if (b) begin
        m_granted = 1; m_hold = 0;
      end
    end else begin
      m_hold = (m_hold < MH) ? m_hold + 1 : MH;
      others = r & ~(4'b0001 << m_owner);
      if (!r[m_owner] || (TO_EN && m_hold == MH && others != 0)) begin
        m_to = r[m_owner];
        m_granted = 0; m_br = 0; m_leaving = 1;
        m_ptr = (m_owner + 1) % N;
      end else if (!b) begin
        m_granted = 0;
      end
    end
  endtask

  function automatic logic [8:0] model_exp();
    logic [3:0] g;
    g = m_granted ? (4'b0001 << m_owner) : 4'b0000;
    return {g, m_br, 2'(m_owner), m_active, m_to};
  endfunction

  initial begin
    int w, cnt, pulses;
    int order [5];
    logic [3:0] r;
    logic b;

    // Single master, abort, re-request, revoke, release-with-revoke.
    tbl[0]  = mk(4'b0100, 0, 4'b0000, 1, 2, 1);
    tbl[1]  = mk(4'b0100, 0, 4'b0000, 1, 2, 1);
    tbl[2]  = mk(4'b0100, 0, 4'b0000, 1, 2, 1);
    tbl[3]  = mk(4'b0100, 0, 4'b0000, 1, 2, 1);
    tbl[4]  = mk(4'b0100, 1, 4'b0100, 1, 2, 1);
    tbl[5]  = mk(4'b0100, 1, 4'b0100, 1, 2, 1);
    tbl[6]  = mk(4'b0000, 1, 4'b0000, 0, 2, 1);
    tbl[7]  = mk(4'b0000, 1, 4'b0000, 0, 2, 1);
    tbl[8]  = mk(4'b0000, 0, 4'b0000, 0, 2, 0);
    tbl[9]  = mk(4'b0010, 0, 4'b0000, 1, 1, 1);
    tbl[10] = mk(4'b0000, 0, 4'b0000, 0, 1, 1);
    tbl[11] = mk(4'b0000, 0, 4'b0000, 0, 1, 0);
    tbl[12] = mk(4'b0010, 0, 4'b0000, 1, 1, 1);
    tbl[13] = mk(4'b0010, 1, 4'b0010, 1, 1, 1);
    tbl[14] = mk(4'b0000, 1, 4'b0000, 0, 1, 1);
    tbl[15] = mk(4'b1001, 0, 4'b0000, 0, 1, 0);
    tbl[16] = mk(4'b1001, 0, 4'b0000, 1, 3, 1);
    tbl[17] = mk(4'b1001, 1, 4'b1000, 1, 3, 1);
    tbl[18] = mk(4'b1001, 0, 4'b0000, 1, 3, 1);
    tbl[19] = mk(4'b1001, 1, 4'b1000, 1, 3, 1);
    tbl[20] = mk(4'b0001, 0, 4'b0000, 0, 3, 1);
    tbl[21] = mk(4'b0001, 0, 4'b0000, 0, 3, 0);
    tbl[22] = mk(4'b0001, 0, 4'b0000, 1, 0, 1);
    tbl[23] = mk(4'b0000, 0, 4'b0000, 0, 0, 1);
    tbl[24] = mk(4'b0000, 0, 4'b0000, 0, 0, 0);

    mc_rst_n  = 1'b0;
    ext_req_i = '0;
    mc_bg_i   = 1'b0;
    tick();
    check("reset_outputs", outs(), 9'h000);
    do_reset();

    for (int i = 0; i < 25; i++) begin
      ext_req_i = tbl[i].req;
      mc_bg_i   = tbl[i].bg;
      tick();
      check($sformatf("vec%0d", i), outs(),
            {tbl[i].gnt, tbl[i].br, tbl[i].owner, tbl[i].busy, 1'b0});
    end

    // Round-robin: all masters request, each releases after 5 granted cycles.
    do_reset();
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    ext_req_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (ext_gnt_o == 4'b0000 && w < 30) begin
        mc_bg_i = mc_br_o;
        tick();
        w++;
      end
      check($sformatf("rr_grant%0d", k), ext_gnt_o, 4'b0001 << order[k]);
      for (int c = 0; c < 4; c++) begin
        mc_bg_i = mc_br_o;
        tick();
      end
      check($sformatf("rr_hold%0d", k), ext_gnt_o, 4'b0001 << order[k]);
      ext_req_i[order[k]] = 1'b0;
      mc_bg_i = mc_br_o;
      tick();
      check($sformatf("rr_release%0d", k), {ext_gnt_o, mc_br_o}, 5'b00000);
      ext_req_i = 4'hF;
    end

    // Asynchronous reset while master 1 owns the bus.
    do_reset();
    ext_req_i = 4'b0010;
    tick();
    mc_bg_i = 1'b1;
    tick();
    check("pre_reset_grant", ext_gnt_o, 4'b0010);
    #2;
    mc_rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs(), 9'h000);
    ext_req_i = '0;
    mc_bg_i   = 1'b0;
    tick();
    mc_rst_n = 1'b1;
    tick();
    check("idle_after_reset", outs(), 9'h000);

`ifdef MC_ARB_TIMEOUT_EN
    // Master 0 holds while master 2 waits: forced release after MH cycles.
    do_reset();
    ext_req_i = 4'b0101;
    w = 0;
    while (ext_gnt_o != 4'b0001 && w < 30) begin
      mc_bg_i = mc_br_o;
      tick();
      w++;
    end
    cnt = 0;
    pulses = 0;
    w = 0;
    while (ext_gnt_o == 4'b0001 && w < 40) begin
      cnt++;
      mc_bg_i = mc_br_o;
      tick();
      w++;
      if (timeout_o) pulses++;
    end
    check("to_hold_cycles", cnt, MH);
    while (ext_gnt_o != 4'b0100 && w < 80) begin
      mc_bg_i = mc_br_o;
      tick();
      w++;
      if (timeout_o) pulses++;
    end
    check("to_next_owner", ext_gnt_o, 4'b0100);
    check("to_pulse_count", pulses, 1);
`endif

    // Random stimulus against the reference model.
    do_reset();
    r = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int bi = 0; bi < N; bi++) begin
        if ($urandom_range(0, 7) == 0) r[bi] = ~r[bi];
      end
      if ($urandom_range(0, 9) < 8) b = m_br;
      else b = 1'($urandom_range(0, 1));
      ext_req_i = r;
      mc_bg_i   = b;
      tick();
      model_step(r, b);
      check($sformatf("rand_c%0d", c), outs(), model_exp());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ext_bus_arbiter.md
# mc_ext_bus_arbiter

Arbitrates several external bus masters for the memory controller's shared external memory bus and drives the controller's bus-request/bus-grant handshake. Sits directly upstream of the memory-side interface: its `mc_br_o` feeds the controller's `mc_br_i`, and it consumes the controller's `mc_bg_o` as `mc_bg_i`. It grants ownership to exactly one master at a time, using round-robin priority.

## Interface
- `NUM_MASTERS`, default 4: number of external masters, 2..8.
- `MAX_HOLD`, default 255: maximum ownership cycles before forced release when another master is waiting. Applies only when `MC_ARB_TIMEOUT_EN` is defined.

Ports:
- `mc_clk`  in  1  memory controller clock; all logic on the rising edge.
- `mc_rst_n`  in  1  asynchronous, active-low reset.
- `ext_req_i`  in  NUM_MASTERS  per-master request; held high for the whole bus tenure.
- `ext_gnt_o`  out  NUM_MASTERS  per-master grant, one-hot or zero.
- `mc_br_o`  out  1  bus request to the controller (`mc_br_i`).
- `mc_bg_i`  in  1  bus grant from the controller (`mc_bg_o`).
- `owner_o`  out  $clog2(NUM_MASTERS)  index of the current or pending owner.
- `busy_o`  out  1  high in any state other than IDLE.
- `timeout_o`  out  1  one-cycle pulse on a forced release.

## Operation
- State machine has four states: IDLE, REQ, OWN, REL.
- **Reset values:** all outputs 0, state IDLE, `rr_ptr` 0, hold counter 0.
- **IDLE:**
  - If any `ext_req_i` bit is high, select the first requesting master at or after `rr_ptr`, searching cyclically.
  - Latch that index into `owner_o`, set `mc_br_o`=1, and go to REQ.
- **REQ:**
  - If `ext_req_i[owner]` drops, clear `mc_br_o` and go to REL; no grant is given and `rr_ptr` is unchanged.
  - Otherwise, when `mc_bg_i`=1, set `ext_gnt_o[owner]`=1, clear the hold counter, and go to OWN.
- **OWN:**
  - The hold counter increments every cycle and saturates at `MAX_HOLD`.
  - If `ext_req_i[owner]`=0, clear the grant and `mc_br_o`, set `rr_ptr`=(owner+1) mod NUM_MASTERS, and go to REL.
  - If `mc_bg_i` drops (the controller revokes the bus), clear the grant, keep `mc_br_o`=1, and go to REQ. The same owner keeps priority.
  - If both conditions occur in the same cycle, release takes priority.
- **REL:** wait for `mc_bg_i`=0, then go to IDLE. No new request is issued until the controller drops its grant.
- **Grant invariants:** `ext_gnt_o` is never high unless `mc_bg_i` was sampled high on the previous edge, and at most one bit is set.
- **Requests in other states:** requests from other masters during REQ/OWN/REL are ignored until the next IDLE evaluation.
- **Reset mid-operation:** all outputs clear asynchronously, and the FSM returns to IDLE.

## Timing
- Request to bus request: `ext_req_i` sampled high at edge N gives `mc_br_o` high after edge N (1-cycle latency).
- Bus grant to master grant: `mc_bg_i` sampled high at edge K gives `ext_gnt_o` high after edge K.
- Release: `ext_req_i[owner]` sampled low at edge M gives `ext_gnt_o` and `mc_br_o` low after edge M.
- Back-to-back tenures: minimum 1 cycle in REL plus 1 cycle in IDLE between two owners.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `MC_ARB_TIMEOUT_EN` defined:
  - When in OWN with the hold counter at `MAX_HOLD` and any other `ext_req_i` bit high, perform a forced release.
  - A forced release does the following: clears the grant and `mc_br_o`, pulses `timeout_o` for 1 cycle, advances `rr_ptr`, and goes to REL.
  - If no other master is requesting, the counter stays saturated and ownership continues.
- `MC_ARB_TIMEOUT_EN` undefined:
  - No hold counter is implemented.
  - `timeout_o` is tied to 0.
  - Ownership is unlimited.

## Test plan
- **Reset:** assert `mc_rst_n`=0 mid-OWN with grant 4'b0010 -> all outputs 0 immediately; state is IDLE after release.
- **Single master:** `ext_req_i`=4'b0100, `mc_bg_i` raised 3 cycles after `mc_br_o` -> `ext_gnt_o`=4'b0100 one cycle later, `owner_o`=2. Drop the request -> grant and `mc_br_o` clear next cycle.
- **Round-robin:** all four masters requesting continuously, each releasing after 5 cycles -> grant order 0,1,2,3,0.
- **Abort before grant:** master 1 drops its request while in REQ -> `mc_br_o` falls, no grant is issued, next grant goes to master 1 again if it re-requests.
- **Controller revoke:** drop `mc_bg_i` during OWN of master 3 -> `ext_gnt_o` goes to 0 next cycle, `mc_br_o` stays 1. Re-raise `mc_bg_i` -> master 3 is re-granted.
- **Timeout** (`MC_ARB_TIMEOUT_EN`, `MAX_HOLD`=8): master 0 holds while master 2 requests -> grant drops after 8 OWN cycles, `timeout_o` pulses once, master 2 is granted next.
